// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one RAM port between the instruction-fetch requester and the
// data-memory requester. One request is granted at a time from IDLE and is
// latched; the RAM request is then held until the RAM reports ACCESS. RAM
// ERROR responses are re-issued a bounded number of times, each grant is
// bounded by a timeout, and a starvation counter guarantees fetch progress
// while data traffic is continuous.
//
// Ports
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   iREN, iaddr          instruction read request / address
//   iload, iwait         instruction read data / stall
//   dREN, dWEN           data read / write request (mutually exclusive)
//   daddr, dstore        data address / write value
//   dload, dwait         data read data / stall
//   ramREN, ramWEN       RAM read / write enable
//   ramaddr, ramstore    RAM address / write data
//   ramload, ramstate    RAM read data / status (FREE, BUSY, ACCESS, ERROR)
//   err                  sticky flag: timeout or retries exhausted
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int TIMEOUT      = 255,
  parameter int MAX_RETRY    = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISERV = 2'd1,
    DSERV = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [31:0]   lat_addr, lat_addr_n;
  logic [31:0]   lat_data, lat_data_n;
  logic          lat_wr, lat_wr_n;      // latched kind: 1 = write, 0 = read
  logic [RW-1:0] retry_cnt, retry_n;
  logic [TW-1:0] tmo_cnt, tmo_n;
  logic [SW-1:0] starve_cnt, starve_n;
  logic          err_n;

  logic          iack, dack;
  logic          req_en;                // enable of the requester in service
  logic          abort;
  logic          retry_out;
  logic          tmo_out;

  // Next-state and output logic.
  // NOTE: every signal gets a default before the case statement, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_n    = state;
    lat_addr_n = lat_addr;
    lat_data_n = lat_data;
    lat_wr_n   = lat_wr;
    retry_n    = retry_cnt;
    tmo_n      = tmo_cnt;
    starve_n   = starve_cnt;
    err_n      = err;
    iack       = 1'b0;
    dack       = 1'b0;
    req_en     = (state == ISERV) ? iREN : dREN;
    abort      = 1'b0;
    retry_out  = 1'b0;
    tmo_out    = 1'b0;

    case (state)
      IDLE: begin
        // Data wins a tie unless fetch has already been passed over
        // STARVE_LIMIT times in a row.
        if ((dREN || dWEN) && !(iREN && starve_cnt == SW'(STARVE_LIMIT))) begin
          lat_addr_n = daddr;
          lat_data_n = dstore;
          lat_wr_n   = dWEN;
          starve_n   = iREN ? starve_cnt + SW'(1) : '0;
          state_n    = DSERV;
        end else if (iREN) begin
          lat_addr_n = iaddr;
          lat_wr_n   = 1'b0;
          starve_n   = '0;
          state_n    = ISERV;
        end
      end

      ISERV, DSERV: begin
        // A read whose requester has gone away is dropped silently; a latched
        // write always runs to completion.
        abort     = !lat_wr && !req_en;
        retry_out = (ramstate == RAM_ERROR) && (retry_cnt == RW'(MAX_RETRY));
        // The counter holds the number of earlier service cycles, so this
        // fires in the TIMEOUT-th cycle of the grant.
        tmo_out   = (tmo_cnt == TW'(TIMEOUT - 1));

        if (abort) begin
          retry_n = '0;
          tmo_n   = '0;
          state_n = IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          iack    = (state == ISERV);
          dack    = (state == DSERV);
          retry_n = '0;
          tmo_n   = '0;
          state_n = IDLE;
        end else if (retry_out || tmo_out) begin
          iack    = (state == ISERV);
          dack    = (state == DSERV);
          err_n   = 1'b1;
          retry_n = '0;
          tmo_n   = '0;
          state_n = IDLE;
        end else begin
          tmo_n = tmo_cnt + TW'(1);
          if (ramstate == RAM_ERROR) begin
            retry_n = retry_cnt + RW'(1);
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      lat_addr   <= '0;
      lat_data   <= '0;
      lat_wr     <= 1'b0;
      retry_cnt  <= '0;
      tmo_cnt    <= '0;
      starve_cnt <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      lat_addr   <= lat_addr_n;
      lat_data   <= lat_data_n;
      lat_wr     <= lat_wr_n;
      retry_cnt  <= retry_n;
      tmo_cnt    <= tmo_n;
      starve_cnt <= starve_n;
      err        <= err_n;
    end
  end

  // Address and write data come straight from the latches, so they hold
  // their last value in IDLE; only the enables depend on the state.
  assign ramaddr  = lat_addr;
  assign ramstore = lat_data;
  assign ramREN   = (state != IDLE) && !lat_wr;
  assign ramWEN   = (state != IDLE) && lat_wr;

  assign iwait = iREN && !iack;
  assign dwait = (dREN || dWEN) && !dack;
  assign iload = ramload;
  assign dload = ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Bench for mem_arbiter. The stimulus side builds transactions (address, data,
// kind and a scripted RAM status sequence), runs them through a transaction-
// level reference model that decides grant order and completion cycle, pushes
// the expected completions into a scoreboard queue and hands the RAM scripts
// to a RAM model. A separate monitor pops and compares on every ack.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int TMO  = 8;
  localparam int MAXR = 3;
  localparam int SLIM = 4;

  localparam logic [1:0] S_FREE   = 2'd0;
  localparam logic [1:0] S_BUSY   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_ERROR  = 2'd3;

  typedef struct {
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [31:0]      rdata;
    bit               wr;
    logic [15:0][1:0] st;     // RAM status for service cycles 1..16
  } txn_t;

  typedef struct {
    bit          is_data;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          cyc;
    bit          err_before;
  } exp_t;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        err;

  mem_arbiter #(
    .TIMEOUT      (TMO),
    .MAX_RETRY    (MAXR),
    .STARVE_LIMIT (SLIM)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iload    (iload),
    .iwait    (iwait),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dload    (dload),
    .dwait    (dwait),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .err      (err)
  );

  int   vec      = 0;
  int   misc     = 0;
  int   cyc      = 0;
  int   m_starve = 0;
  bit   m_err    = 1'b0;
  bit   i_done   = 1'b0;
  bit   d_done   = 1'b0;

  txn_t itx[$];
  txn_t dtx[$];
  txn_t ram_q[$];
  exp_t exp_q[$];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      misc++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------- helpers
  function automatic logic [15:0][1:0] seq(input int nb, input int ne, input bit acc);
    logic [15:0][1:0] s;
    int p;
    for (int j = 0; j < 16; j++) s[j] = S_BUSY;
    p = nb;
    for (int j = 0; j < ne; j++) begin
      if (p < 16) s[p] = S_ERROR;
      p++;
    end
    if (acc && p < 16) s[p] = S_ACCESS;
    return s;
  endfunction

  function automatic logic [15:0][1:0] rand_seq();
    logic [15:0][1:0] s;
    int r;
    for (int j = 0; j < 16; j++) begin
      r = $urandom_range(0, 9);
      if (r < 5)       s[j] = S_BUSY;
      else if (r == 5) s[j] = S_FREE;
      else if (r < 8)  s[j] = S_ERROR;
      else             s[j] = S_ACCESS;
    end
    return s;
  endfunction

  function automatic txn_t mk_txn(input logic [31:0] addr, input logic [31:0] wdata,
                                  input bit wr, input logic [31:0] rdata,
                                  input logic [15:0][1:0] st);
    txn_t t;
    t.addr  = addr;
    t.wdata = wdata;
    t.wr    = wr;
    t.rdata = rdata;
    t.st    = st;
    return t;
  endfunction

  // Reference rule for one grant: the service cycle (1-based) in which it
  // completes, and whether that completion is an error.
  function automatic int svc(input logic [15:0][1:0] st, output bit e);
    int errs;
    logic [1:0] s;
    errs = 0;
    e    = 1'b0;
    for (int k = 1; k <= TMO; k++) begin
      s = (k <= 16) ? st[k-1] : S_BUSY;
      if (s == S_ACCESS) return k;
      if (s == S_ERROR) begin
        if (errs == MAXR) begin
          e = 1'b1;
          return k;
        end
        errs++;
      end
      if (k == TMO) begin
        e = 1'b1;
        return k;
      end
    end
    e = 1'b1;
    return TMO;
  endfunction

  task automatic drive_i(input int idx);
    if (idx < itx.size()) begin
      iREN  = 1'b1;
      iaddr = itx[idx].addr;
    end else begin
      iREN = 1'b0;
    end
  endtask

  task automatic drive_d(input int idx);
    if (idx < dtx.size()) begin
      daddr  = dtx[idx].addr;
      dstore = dtx[idx].wdata;
      dREN   = !dtx[idx].wr;
      dWEN   = dtx[idx].wr;
    end else begin
      dREN = 1'b0;
      dWEN = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #2;
    nRST = 1'b0;
    iREN = 1'b0;
    dREN = 1'b0;
    dWEN = 1'b0;
    #1;
    check("rst_ramREN",   ramREN,   0);
    check("rst_ramWEN",   ramWEN,   0);
    check("rst_ramaddr",  ramaddr,  0);
    check("rst_ramstore", ramstore, 0);
    check("rst_err",      err,      0);
    check("rst_iwait",    iwait,    0);
    check("rst_dwait",    dwait,    0);
    exp_q.delete();
    ram_q.delete();
    m_starve = 0;
    m_err    = 1'b0;
    i_done   = 1'b0;
    d_done   = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    nRST = 1'b1;
  endtask

  // Runs everything queued in itx/dtx. Each requester holds its request
  // continuously and moves to its next transaction after its ack.
  task automatic run_round();
    int   ni, nd, ii, di, cur, c, k;
    bit   e, ireq, dreq, gd;
    txn_t tx;
    exp_t x;
    ni = itx.size();
    nd = dtx.size();
    @(posedge CLK);
    #1;
    cur = cyc;
    ii  = 0;
    di  = 0;
    while (ii < ni || di < nd) begin
      ireq = (ii < ni);
      dreq = (di < nd);
      gd   = dreq && !(ireq && m_starve == SLIM);
      if (gd) begin
        tx = dtx[di];
        di++;
        m_starve = ireq ? m_starve + 1 : 0;
      end else begin
        tx = itx[ii];
        ii++;
        m_starve = 0;
      end
      c = svc(tx.st, e);
      ram_q.push_back(tx);
      x.is_data    = gd;
      x.wr         = tx.wr;
      x.addr       = tx.addr;
      x.wdata      = tx.wdata;
      x.rdata      = tx.rdata;
      x.cyc        = cur + c;
      x.err_before = m_err;
      exp_q.push_back(x);
      m_err = m_err | e;
      cur   = cur + c + 1;
    end

    i_done = 1'b0;
    d_done = 1'b0;
    ii = 0;
    di = 0;
    drive_i(0);
    drive_d(0);
    k = 0;
    while ((ii < ni || di < nd) && k < 300) begin
      @(posedge CLK);
      #1;
      k++;
      if (i_done) begin
        i_done = 1'b0;
        ii++;
        drive_i(ii);
      end
      if (d_done) begin
        d_done = 1'b0;
        di++;
        drive_d(di);
      end
    end

    if (ii < ni || di < nd) begin
      vec++;
      misc++;
      $display("FAIL round_timeout: fetch %0d/%0d data %0d/%0d acks seen", ii, ni, di, nd);
      do_reset();
    end else begin
      check("idle_ramREN",   ramREN,        0);
      check("idle_ramWEN",   ramWEN,        0);
      check("err_sticky",    err,           m_err);
      check("exp_q_drained", exp_q.size(),  0);
      check("ram_q_drained", ram_q.size(),  0);
    end
    itx.delete();
    dtx.delete();
  endtask

  // --------------------------------------------------------------- RAM model
  initial begin : ram_model
    txn_t cur_t;
    bit   active;
    int   idx;
    active   = 1'b0;
    idx      = 0;
    cur_t    = mk_txn(0, 0, 0, 0, seq(16, 0, 0));
    ramstate = S_FREE;
    ramload  = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (ramREN || ramWEN) begin
        if (!active) begin
          active = 1'b1;
          idx    = 0;
          if (ram_q.size() > 0) cur_t = ram_q.pop_front();
          else                  cur_t = mk_txn(0, 0, 0, 32'hFFFF_FFFF, seq(16, 0, 0));
        end
        ramstate = (idx < 16) ? cur_t.st[idx] : S_BUSY;
        ramload  = cur_t.rdata;
        idx++;
      end else begin
        active   = 1'b0;
        ramstate = S_FREE;
        ramload  = $urandom;
      end
    end
  end

  // ----------------------------------------------------------------- monitor
  task automatic check_ack(input bit is_d);
    exp_t e;
    if (exp_q.size() == 0) begin
      vec++;
      misc++;
      $display("FAIL unexpected_ack: got ack from %s expected none (cycle %0d)",
               is_d ? "data" : "fetch", cyc);
    end else begin
      e = exp_q.pop_front();
      check("ack_source", is_d,    e.is_data);
      check("ack_cycle",  cyc,     e.cyc);
      check("ramaddr",    ramaddr, e.addr);
      check("ramREN",     ramREN,  !e.wr);
      check("ramWEN",     ramWEN,  e.wr);
      if (e.wr) check("ramstore", ramstore, e.wdata);
      else      check("load",     is_d ? dload : iload, e.rdata);
      check("err_at_ack", err, e.err_before);
    end
    if (is_d) d_done = 1'b1;
    else      i_done = 1'b1;
  endtask

  initial begin : monitor
    forever begin
      @(negedge CLK);
      if (nRST) begin
        if (iREN && !iwait)          check_ack(1'b0);
        if ((dREN || dWEN) && !dwait) check_ack(1'b1);
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    nRST   = 1'b0;
    iREN   = 1'b0;
    iaddr  = '0;
    dREN   = 1'b0;
    dWEN   = 1'b0;
    daddr  = '0;
    dstore = '0;
    do_reset();

    // Lone fetch: two BUSY cycles then ACCESS.
    itx.push_back(mk_txn(32'h40, 0, 1'b0, 32'h8C01_0004, seq(2, 0, 1'b1)));
    run_round();

    // Contention: write wins, one IDLE cycle, then fetch.
    dtx.push_back(mk_txn(32'h100, 32'hDEAD_BEEF, 1'b1, 0, seq(0, 0, 1'b1)));
    itx.push_back(mk_txn(32'h44, 0, 1'b0, 32'h1234_5678, seq(1, 0, 1'b1)));
    run_round();

    // Starvation: continuous data reads while fetch waits.
    for (int j = 0; j < 6; j++)
      dtx.push_back(mk_txn(32'h300 + 32'(j * 4), 0, 1'b0, $urandom, seq(0, 0, 1'b1)));
    itx.push_back(mk_txn(32'h48, 0, 1'b0, 32'h0000_ABCD, seq(0, 0, 1'b1)));
    run_round();

    // Error retry: recovers after two errors, then exhausts on four.
    dtx.push_back(mk_txn(32'h500, 0, 1'b0, 32'hCAFE_F00D, seq(0, 2, 1'b1)));
    run_round();
    dtx.push_back(mk_txn(32'h504, 0, 1'b0, 32'h0BAD_F00D, seq(0, 4, 1'b1)));
    run_round();
    do_reset();

    // Timeout: write stuck BUSY.
    dtx.push_back(mk_txn(32'h600, 32'hA5A5_A5A5, 1'b1, 0, seq(16, 0, 1'b0)));
    run_round();
    do_reset();

    // Fetch abort in the second service cycle, then a long fetch that would
    // time out early if the abort left the counters dirty.
    @(posedge CLK);
    #1;
    ram_q.push_back(mk_txn(32'h80, 0, 1'b0, 0, seq(16, 0, 1'b0)));
    iaddr = 32'h80;
    iREN  = 1'b1;
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;
    iREN = 1'b0;
    #3;
    check("abort_ren_held", ramREN, 1);
    @(posedge CLK);
    #1;
    check("abort_idle_ren", ramREN, 0);
    check("abort_err",      err,    0);
    m_starve = 0;
    itx.push_back(mk_txn(32'h84, 0, 1'b0, 32'h5555_AAAA, seq(6, 0, 1'b1)));
    run_round();

    // Asynchronous reset in the middle of a write.
    @(posedge CLK);
    #1;
    ram_q.push_back(mk_txn(32'h200, 32'h1357_9BDF, 1'b1, 0, seq(16, 0, 1'b0)));
    daddr  = 32'h200;
    dstore = 32'h1357_9BDF;
    dWEN   = 1'b1;
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;
    check("mid_wen_active", ramWEN, 1);
    #2;
    nRST = 1'b0;
    #1;
    check("mid_rst_wen", ramWEN, 0);
    check("mid_rst_ren", ramREN, 0);
    check("mid_rst_err", err,    0);
    dWEN = 1'b0;
    @(posedge CLK);
    #2;
    nRST = 1'b1;
    exp_q.delete();
    ram_q.delete();
    m_starve = 0;
    m_err    = 1'b0;
    dtx.push_back(mk_txn(32'h204, 32'h2468_ACE0, 1'b1, 0, seq(1, 0, 1'b1)));
    run_round();

    // Randomized traffic.
    for (int r = 0; r < 40; r++) begin
      int ni, nd;
      ni = $urandom_range(0, 2);
      nd = $urandom_range(0, 5);
      if (ni == 0 && nd == 0) ni = 1;
      for (int j = 0; j < ni; j++)
        itx.push_back(mk_txn($urandom & 32'hFFFF_FFFC, 0, 1'b0, $urandom, rand_seq()));
      for (int j = 0; j < nd; j++)
        dtx.push_back(mk_txn($urandom & 32'hFFFF_FFFC, $urandom, 1'($urandom_range(0, 1)),
                             $urandom, rand_seq()));
      run_round();
      if (m_err || $urandom_range(0, 9) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, misc);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single shared RAM port between the pipeline's instruction fetch requester and data memory requester.
- Sits between the datapath-side cache interface and the RAM model.
- Latches one granted request at a time and holds the RAM request until the RAM reports ACCESS.
- Handles RAM ERROR with bounded retries, bounds each access with a timeout, and prevents data traffic from starving fetch.

Parameters:
- TIMEOUT, 255, maximum cycles one grant may stay in service before forced completion.
- MAX_RETRY, 3, number of RAM ERROR responses re-issued before forced completion.
- STARVE_LIMIT, 4, consecutive data grants allowed while iREN is pending before fetch is forced.

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  instruction read request
- iaddr  in  32  instruction address
- iload  out  32  instruction read data, valid when iREN & ~iwait
- iwait  out  1  instruction stall
- dREN  in  1  data read request
- dWEN  in  1  data write request (never asserted together with dREN)
- daddr  in  32  data address
- dstore  in  32  data write value
- dload  out  32  data read data, valid when dREN & ~dwait
- dwait  out  1  data stall
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
- err  out  1  sticky error flag: timeout or retries exhausted

Behaviour:
- Reset (async, nRST low) forces:
  - state IDLE; ramREN/ramWEN 0; ramaddr/ramstore 0; err 0.
  - retry, timeout and starve counters 0; latched address, data and kind 0.
- iwait = iREN & ~iack and dwait = (dREN|dWEN) & ~dack. The ack terms are combinational, high only in the completion cycle.
- iload = dload = ramload (combinational pass-through).
- States: IDLE, ISERV, DSERV.
- IDLE:
  - No RAM request is driven.
  - If dREN|dWEN and not (iREN & starve==STARVE_LIMIT): grant data. Latch daddr, dstore and kind (read/write); next state DSERV. If iREN was high, starve++; otherwise starve=0.
  - Else if iREN: grant fetch. Latch iaddr; starve=0; next state ISERV.
  - Else stay in IDLE.
  - Minimum latency from request to first RAM cycle is 1 cycle (registered grant).
- ISERV/DSERV:
  - ramaddr and ramstore are driven from the latches.
  - ramREN = latched read kind; ramWEN = latched write kind.
  - The timeout counter increments every cycle in service.
  - ramstate ACCESS: ack the granted requester this cycle; clear retry and timeout counters; go to IDLE next edge.
  - ramstate ERROR: if retry < MAX_RETRY, retry++ and keep the request asserted. Otherwise ack, set err, go to IDLE.
  - Timeout counter reaches TIMEOUT with no ACCESS: ack, set err, go to IDLE. ACCESS in that same cycle wins and does not set err.
  - Read abort: if the granted requester's enable is low in a service cycle, go to IDLE next edge with no ack. Counters clear and ram enables stay driven that cycle.
  - Writes never abort; a latched write runs to ACCESS, retry exhaustion, or timeout.
  - New requests arriving while in service are not sampled until IDLE. There is always at least one IDLE cycle between grants.
  - ramaddr and ramstore hold their last value in IDLE; only the enables drop.
- Simultaneous dREN/dWEN and iREN in IDLE: data wins unless the starve count has reached STARVE_LIMIT.
- err stays set until reset.
- Counter widths: timeout is $clog2(TIMEOUT+1) bits; retry and starve are sized likewise. No wrap is reachable.

Test Plan:
- Lone fetch: iREN=1, iaddr=0x40; RAM gives BUSY for 2 cycles, then ACCESS with ramload=0x8C010004.
  - Expected: ramREN high from cycle 1 to cycle 3; iwait low only in cycle 3; iload=0x8C010004; IDLE in cycle 4.
- Contention: iREN and dWEN raised together, daddr=0x100, dstore=0xDEADBEEF.
  - Expected: data served first with ramWEN=1, ramaddr=0x100, ramstore=0xDEADBEEF.
  - After ACCESS, one IDLE cycle, then fetch is granted.
- Starvation: iREN held while dREN is re-asserted continuously (ACCESS on first service cycle).
  - Expected: exactly 4 data grants, then a fetch grant, then starve reset to 0.
- Error retry: data read with ramstate ERROR, ERROR, ACCESS.
  - Expected: dwait low only on the ACCESS cycle; err stays 0.
  - With 4 ERRORs: ack on the 4th ERROR and err=1.
- Timeout and abort:
  - TIMEOUT=8 with ramstate stuck BUSY: dack in the 8th service cycle, err=1.
  - Separate run: iREN dropped in 2nd service cycle. Expected: no ack, IDLE next edge, err=0.
- Async reset mid-service: nRST pulled low between edges during DSERV write.
  - Expected: ramWEN drops to 0 immediately, state IDLE, err 0; normal request after release served.
